// File: rtl/wave_capture.sv
// wave_capture: triggered capture of one 256-sample audio frame into the
// inactive half of a 512x8 ping-pong sample RAM, with the display half
// swapped only during vertical blanking.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous active-low reset
//   new_sample_ready  one-cycle strobe qualifying new_sample_in
//   new_sample_in     signed two's-complement audio sample
//   wave_display_idle high during display vertical blanking
//   write_address     RAM write address {~read_index, count}
//   write_enable      one-cycle RAM write strobe
//   write_sample      offset-binary 8-bit sample
//   read_index        RAM half currently read by the display
module wave_capture #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic                wave_display_idle,
  output logic [8:0]          write_address,
  output logic                write_enable,
  output logic [7:0]          write_sample,
  output logic                read_index
);

  // Timeout counter only has to reach TIMEOUT-1.
  localparam int unsigned TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TCNT_MAX = (TIMEOUT > 1) ? TCNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } state_e;

  state_e            state_q;
  logic [7:0]        count_q;
  logic              prev_neg_q;   // only the sign of the previous sample matters
  logic [TCNT_W-1:0] tcnt_q;
  logic              idle_q;
  logic              rd_idx_q;
  logic              we_q;
  logic [8:0]        waddr_q;
  logic [7:0]        wdata_q;

  logic              crossing;
  logic              timed_out;
  logic              idle_rise;
  logic [7:0]        sample_ob;
  logic              unused_lsbs;

  // Negative-to-non-negative transition; zero counts as non-negative.
  assign crossing  = prev_neg_q & ~new_sample_in[SAMPLE_W-1];
  assign timed_out = (TIMEOUT != 0) && (tcnt_q == TCNT_MAX);
  assign idle_rise = wave_display_idle & ~idle_q;

  // Offset binary: flip the sign bit and keep the top 7 magnitude bits.
  assign sample_ob   = {~new_sample_in[SAMPLE_W-1], new_sample_in[SAMPLE_W-2 -: 7]};
  assign unused_lsbs = ^new_sample_in[SAMPLE_W-9:0];

  // Capture FSM with registered RAM write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_ARMED;
      count_q    <= 8'd0;
      prev_neg_q <= 1'b0;
      tcnt_q     <= '0;
      idle_q     <= 1'b0;
      rd_idx_q   <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= 9'd0;
      wdata_q    <= 8'd0;
    end else begin
      we_q   <= 1'b0;
      idle_q <= wave_display_idle;

      if (new_sample_ready) begin
        prev_neg_q <= new_sample_in[SAMPLE_W-1];
      end

      case (state_q)
        ST_ARMED: begin
          if (new_sample_ready) begin
            if (crossing || timed_out) begin
              // Triggering sample is the first sample of the frame.
              we_q    <= 1'b1;
              waddr_q <= {~rd_idx_q, 8'h00};
              wdata_q <= sample_ob;
              count_q <= 8'd1;
              state_q <= ST_ACTIVE;
            end else if (tcnt_q != TCNT_MAX) begin
              tcnt_q <= tcnt_q + TCNT_W'(1);
            end
          end
        end

        ST_ACTIVE: begin
          if (new_sample_ready) begin
            we_q    <= 1'b1;
            waddr_q <= {~rd_idx_q, count_q};
            wdata_q <= sample_ob;
            count_q <= count_q + 8'd1;
            if (count_q == 8'hFF) begin
              state_q <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          // Swap halves only on a fresh blanking edge, never mid-frame.
          if (idle_rise) begin
            rd_idx_q <= ~rd_idx_q;
            tcnt_q   <= '0;
            state_q  <= ST_ARMED;
          end
        end

        default: begin
          state_q <= ST_ARMED;
        end
      endcase
    end
  end

  assign write_address = waddr_q;
  assign write_enable  = we_q;
  assign write_sample  = wdata_q;
  assign read_index    = rd_idx_q;

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
- Sits directly upstream of the waveform display stage.
- Watches the audio sample stream and triggers on a positive-going zero crossing.
- Writes 256 consecutive samples, converted to 8-bit offset-binary, into the inactive half of a 512x8 dual-port sample RAM.
- Flips read_index during display blanking so the display always reads a complete, stable buffer.

Parameters:
- SAMPLE_W, 16, width of the signed input audio sample.
- TIMEOUT, 1024, number of samples accepted in ARMED without a crossing before a forced trigger (0 disables the forced trigger).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  SAMPLE_W  signed two's-complement audio sample.
- wave_display_idle  input  1  high during vertical blanking (display vsync).
- write_address  output  9  RAM write address, {~read_index, count[7:0]}.
- write_enable  output  1  one-cycle RAM write strobe.
- write_sample  output  8  offset-binary sample: {~s[SAMPLE_W-1], s[SAMPLE_W-2:SAMPLE_W-8]}.
- read_index  output  1  buffer half the display reads; capture writes the other half.

Behaviour:
- Reset values (reset=0, asynchronous): state=ARMED, count=0, prev_sample=0, timeout counter=0, idle_d=0, read_index=0, write_enable=0, write_address=0, write_sample=0.
- Outputs are registered: write_* update on the clock edge where a sample is accepted, so they are visible one cycle after the new_sample_ready strobe.
- write_enable is high for exactly that one cycle.
- prev_sample is loaded with new_sample_in on every strobe, in every state.
- Samples arriving without a strobe are ignored.
- ARMED:
  - On a strobe, trigger if prev_sample[MSB]=1 and new_sample_in[MSB]=0.
  - Also trigger if TIMEOUT!=0 and the timeout counter has reached TIMEOUT-1.
  - On trigger: the triggering sample is written at count=0, count becomes 1, state goes to ACTIVE.
  - Otherwise the timeout counter increments, saturating at TIMEOUT-1. No write occurs.
- ACTIVE:
  - Each strobe writes the sample at {~read_index, count} and increments count.
  - The strobe with count=255 writes address {~read_index, 8'hFF}, wraps count to 0, and moves to WAIT.
- WAIT:
  - No writes; strobes only update prev_sample.
  - idle_d registers wave_display_idle every cycle.
  - On a rising edge of idle (wave_display_idle=1 and idle_d=0): toggle read_index, clear the timeout counter, go to ARMED.
  - If idle is already high on entry to WAIT, the bench must see it fall and rise again before the toggle. This guarantees exactly one toggle per blanking interval and never a toggle mid-frame.
- read_index changes only in WAIT on an idle rising edge. No write to the half being read is ever issued.
- A strobe in the same cycle as the WAIT-to-ARMED transition updates prev_sample only. Trigger evaluation starts on the next strobe.
- A zero sample counts as non-negative, so the transition -1 -> 0 triggers.
- Reset asserted mid-capture abandons the partial buffer: read_index returns to 0 and the next capture writes half 1.
- Offset conversion examples for SAMPLE_W=16: 0x8000 -> 0x00, 0xFFFF -> 0x7F, 0x0000 -> 0x80, 0x7FFF -> 0xFF.

Test Plan:
- Reset: hold reset=0 while strobing samples -> no write_enable, read_index=0. Release -> state ARMED, all outputs 0.
- Trigger and fill: strobe -5 then +3, then 255 more samples with values 0..254 -> first write addr 0x100 data 0x80 (sample +3 truncated to 0x80). The last write is addr 0x1FF. Exactly 256 write_enable pulses, each one cycle after its strobe.
- Buffer flip: after the fill, hold idle=0 for 10 cycles, then pulse idle=1 for 3 cycles -> read_index toggles 0->1 exactly once, on the first idle-high edge. The next capture writes addresses 0x000..0x0FF.
- Idle already high: finish the fill while idle=1 -> no toggle until idle falls and rises again.
- Timeout: with TIMEOUT=8, strobe constant +100 -> no writes for 7 strobes; the 8th strobe writes addr {~read_index,0x00} with data 0x80.
- Mid-capture reset: assert reset after 100 writes -> write_enable drops at once and read_index=0. After a new trigger, writes restart at 0x100.
